ram_ctrl: RTL
=============

# ram_ctrl

Initiator-side controller for the single-port synchronous RAM: accepts one read or write request at a time from a host over a valid/ready handshake, drives single-cycle `wr_en`/`rd_en` pulses into the RAM, and waits for the RAM's one-cycle `ready` pulse. It then returns write acknowledges or read data to the host, again over a valid/ready handshake. A watchdog aborts requests the RAM never answers. Sits between the host or bus fabric and the RAM macro.

## Interface
- ADDR_WIDTH, 8, RAM address width
- DATA_WIDTH, 8, RAM data width
- TIMEOUT, 15, max cycles spent in WAIT before aborting; must be ≥ 2
- clk  in  1  system clock, all logic on rising edge
- rst_n  in  1  reset, asynchronous, active-low
- req_valid  in  1  host request valid
- req_ready  out  1  controller can accept a request
- req_we  in  1  1 = write, 0 = read
- req_addr  in  ADDR_WIDTH  request address
- req_wdata  in  DATA_WIDTH  write data
- resp_valid  out  1  response valid
- resp_ready  in  1  host accepts response
- resp_rdata  out  DATA_WIDTH  read data; 0 for writes and errors
- resp_err  out  1  response is a timeout abort
- mem_wr_en  out  1  RAM write enable, one-cycle pulse
- mem_rd_en  out  1  RAM read enable, one-cycle pulse
- mem_addr  out  ADDR_WIDTH  RAM address, held from ISSUE through WAIT
- mem_wdata  out  DATA_WIDTH  RAM write data, held with mem_addr
- mem_rdata  in  DATA_WIDTH  RAM read data
- mem_ready  in  1  RAM completion pulse

## Operation
- FSM states: IDLE, ISSUE, WAIT, RESP.
- IDLE:
  - req_ready = 1.
  - On req_valid, latch req_we/req_addr/req_wdata and go to ISSUE.
- ISSUE:
  - Assert exactly one of mem_wr_en or mem_rd_en for one cycle, matching the latched req_we.
  - Clear the watchdog counter and go to WAIT.
- WAIT:
  - mem_wr_en and mem_rd_en are 0.
  - On mem_ready: capture mem_rdata for reads, or 0 for writes, into resp_rdata; set resp_err = 0; go to RESP.
  - Otherwise increment the counter. When the counter reaches TIMEOUT, set resp_err = 1 and resp_rdata = 0, then go to RESP.
- RESP:
  - resp_valid = 1; resp_rdata and resp_err stay stable.
  - On resp_ready, go to IDLE.
- req_ready is 0 in every state except IDLE, so only one transaction is outstanding at a time.
- mem_ready seen in IDLE, ISSUE or RESP is ignored and does not change the response.
- Watchdog counter is $clog2(TIMEOUT+1) bits wide and saturates; it never wraps.
- Reset, including mid-transaction:
  - FSM returns to IDLE and the in-flight request is dropped with no response.
  - Outputs reset to: req_ready = 1, resp_valid = 0, resp_err = 0, resp_rdata = 0, mem_wr_en = 0, mem_rd_en = 0, mem_addr = 0, mem_wdata = 0.

## Timing
- All outputs are registered, except req_ready, which is decoded from the state register.
- Cycle 0: request handshake (req_valid && req_ready).
- Cycle 1: ISSUE; enable pulse high.
- Cycle 2: RAM asserts mem_ready and read data; the controller captures them.
- Cycle 3: resp_valid = 1.
- Nominal latency from handshake to resp_valid is 3 cycles.
- With resp_ready held high:
  - RESP lasts 1 cycle and the next request is accepted in cycle 4.
  - Back-to-back throughput is 1 transaction per 4 cycles.
- Timeout: resp_valid rises TIMEOUT + 2 cycles after the handshake.
- resp_valid must not drop before resp_ready is seen; holding resp_ready low holds RESP indefinitely.

## Structure
- Shared package `ram_ctrl_pkg`:
  - State enum (IDLE/ISSUE/WAIT/RESP).
  - Opcode constants OP_READ = 0, OP_WRITE = 1.
  - Default ADDR_WIDTH/DATA_WIDTH/TIMEOUT localparams.
- One natural sub-module, `ram_ctrl_wdog`: saturating watchdog counter with clear/enable inputs and an `expired` output.
- FSM and datapath registers live in `ram_ctrl`.

## Test plan
- Reset, then write 0xA5 to address 0x10 with the controller connected to the RAM: resp_valid 3 cycles after the handshake, resp_err = 0, resp_rdata = 0, mem_wr_en high for exactly 1 cycle.
- Read address 0x10 after that write: resp_rdata = 0xA5, resp_err = 0, latency 3 cycles; read of untouched address 0x11 returns 0x00.
- Hold resp_ready low for 5 cycles: resp_valid and resp_rdata stay stable, req_ready = 0, and a second req_valid is not accepted until one cycle after resp_ready.
- Stub RAM with mem_ready tied 0 and TIMEOUT = 15: resp_valid at cycle 17 after the handshake, resp_err = 1, resp_rdata = 0; a following normal read succeeds.
- Assert rst_n low during WAIT: all outputs at reset values immediately, no response is produced, and a fresh write of 0x3C to 0x00 after release completes normally.
- Drive 8 back-to-back alternating writes and reads with resp_ready high: each read returns the preceding write's data and requests are accepted every 4 cycles.

Source files
------------

// File: rtl/ram_ctrl_pkg.sv
// ram_ctrl_pkg: shared state encoding, opcodes and default sizes for the RAM controller.
package ram_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT,
        RESP
    } state_t;

    localparam logic OP_READ  = 1'b0;
    localparam logic OP_WRITE = 1'b1;

    localparam int DEFAULT_ADDR_WIDTH = 8;
    localparam int DEFAULT_DATA_WIDTH = 8;
    localparam int DEFAULT_TIMEOUT    = 15;

endpackage

// File: rtl/ram_ctrl_wdog.sv
// ram_ctrl_wdog: saturating watchdog counter; expired flags the last allowed WAIT cycle.
module ram_ctrl_wdog
    import ram_ctrl_pkg::*;
#(
    parameter int TIMEOUT = DEFAULT_TIMEOUT
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic en,
    output logic expired
);

    localparam int CW = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] TOP = CW'(TIMEOUT);
    localparam logic [CW-1:0] LIM = CW'(TIMEOUT - 1);

    logic [CW-1:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            cnt <= '0;
        else if (clr)
            cnt <= '0;
        else if (en && cnt != TOP)
            cnt <= cnt + 1'b1;
    end

    // The increment taken in this cycle would make the count reach TIMEOUT.
    assign expired = cnt >= LIM;

endmodule

// File: rtl/ram_ctrl.sv
// ram_ctrl: single-outstanding request controller between a host and a synchronous RAM.
module ram_ctrl
    import ram_ctrl_pkg::*;
#(
    parameter int ADDR_WIDTH = DEFAULT_ADDR_WIDTH,
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
    parameter int TIMEOUT    = DEFAULT_TIMEOUT
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_we,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    output logic                  resp_valid,
    input  logic                  resp_ready,
    output logic [DATA_WIDTH-1:0] resp_rdata,
    output logic                  resp_err,
    output logic                  mem_wr_en,
    output logic                  mem_rd_en,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    input  logic [DATA_WIDTH-1:0] mem_rdata,
    input  logic                  mem_ready
);

    state_t state, state_nx;
    logic   op_we;
    logic   wd_clr, wd_en, expired;

    ram_ctrl_wdog #(.TIMEOUT(TIMEOUT)) u_wdog (
        .clk     (clk),
        .rst_n   (rst_n),
        .clr     (wd_clr),
        .en      (wd_en),
        .expired (expired)
    );

    assign req_ready = state == IDLE;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= IDLE;
        else
            state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        wd_clr   = 1'b0;
        wd_en    = 1'b0;
        unique case (state)
            IDLE:  state_nx = req_valid ? ISSUE : IDLE;
            ISSUE: begin
                wd_clr   = 1'b1;
                state_nx = WAIT;
            end
            WAIT: begin
                wd_en    = !mem_ready;
                state_nx = (mem_ready || expired) ? RESP : WAIT;
            end
            RESP:  state_nx = resp_ready ? IDLE : RESP;
            default: state_nx = IDLE;
        endcase
    end

    // Enables are launched on the accepting edge so the pulse lands exactly in ISSUE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_we      <= OP_READ;
            mem_wr_en  <= 1'b0;
            mem_rd_en  <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            resp_valid <= 1'b0;
            resp_err   <= 1'b0;
            resp_rdata <= '0;
        end else begin
            mem_wr_en <= 1'b0;
            mem_rd_en <= 1'b0;
            if (state == IDLE && req_valid) begin
                op_we     <= req_we;
                mem_wr_en <= req_we == OP_WRITE;
                mem_rd_en <= req_we == OP_READ;
                mem_addr  <= req_addr;
                mem_wdata <= req_wdata;
            end
            if (state == WAIT && (mem_ready || expired)) begin
                resp_valid <= 1'b1;
                resp_err   <= !mem_ready;
                resp_rdata <= (mem_ready && op_we == OP_READ) ? mem_rdata : '0;
            end
            if (state == RESP && resp_ready)
                resp_valid <= 1'b0;
        end
    end

endmodule
